float_dot_feeder: RTL

// Upstream sequencer for the half-precision dot-product unit (myFloatDot). Buffers two operand

---
 rtl/float_dot_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/float_dot_feeder.sv
// Operand sequencer for the half-precision dot unit: buffers A/B vectors, streams pairs
// with a fixed hold time, drains with zeros, then captures the accumulator result.
module float_dot_feeder #(
    parameter int REG_SIZE = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int HOLD     = 10,
    parameter int DRAIN    = 10,
    parameter int CNT_W    = 8
) (
    input  logic                clk_44,
    input  logic                reset_44,
    input  logic                wr_en_44,
    input  logic [ADDR_W-1:0]   wr_addr_44,
    input  logic [REG_SIZE-1:0] wr_a_44,
    input  logic [REG_SIZE-1:0] wr_b_44,
    input  logic [CNT_W-1:0]    len_44,
    input  logic                start_44,
    input  logic [REG_SIZE-1:0] res_in_44,
    output logic [REG_SIZE-1:0] dataOut1_44,
    output logic [REG_SIZE-1:0] dataOut2_44,
    output logic                acc_clr_44,
    output logic                busy_44,
    output logic                done_44,
    output logic [REG_SIZE-1:0] result_44
);

    localparam int AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [REG_SIZE-1:0] a;
        logic [REG_SIZE-1:0] b;
    } pair_t;

    state_t              state;
    pair_t               pair_mem [DEPTH];
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   nxt_idx;
    logic [AW1-1:0]      len_q;
    logic [CNT_W-1:0]    cnt;
    logic                wr_ok;
    logic                last_pair;
    logic                hold_end;
    logic                drain_end;

    assign wr_ok     = wr_en_44 && (state == S_IDLE || state == S_DONE)
                       && ({1'b0, wr_addr_44} < AW1'(DEPTH));
    assign nxt_idx   = idx + ADDR_W'(1);
    assign last_pair = ({1'b0, idx} == (len_q - AW1'(1)));
    assign hold_end  = (cnt == CNT_W'(HOLD - 1));
    assign drain_end = (cnt == CNT_W'(DRAIN - 1));

    // Operand buffer has no reset; contents are only meaningful once written.
    always_ff @(posedge clk_44) begin
        if (wr_ok) begin
            pair_mem[wr_addr_44] <= '{a: wr_a_44, b: wr_b_44};
        end
    end

    always_ff @(posedge clk_44 or posedge reset_44) begin
        if (reset_44) begin
            state       <= S_IDLE;
            idx         <= '0;
            len_q       <= '0;
            cnt         <= '0;
            dataOut1_44 <= '0;
            dataOut2_44 <= '0;
            acc_clr_44  <= 1'b0;
            busy_44     <= 1'b0;
            done_44     <= 1'b0;
            result_44   <= '0;
        end else begin
            acc_clr_44 <= 1'b0;
            done_44    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_44) begin
                        // Clamp the run length so idx never walks past the buffer.
                        if (len_44 > CNT_W'(DEPTH)) len_q <= AW1'(DEPTH);
                        else                        len_q <= AW1'(len_44);
                        idx        <= '0;
                        cnt        <= '0;
                        acc_clr_44 <= 1'b1;
                        busy_44    <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt <= '0;
                    if (len_q == '0) begin
                        state <= S_DRAIN;
                    end else begin
                        dataOut1_44 <= pair_mem[0].a;
                        dataOut2_44 <= pair_mem[0].b;
                        state       <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (hold_end) begin
                        cnt <= '0;
                        if (last_pair) begin
                            dataOut1_44 <= '0;
                            dataOut2_44 <= '0;
                            state       <= S_DRAIN;
                        end else begin
                            idx         <= nxt_idx;
                            dataOut1_44 <= pair_mem[nxt_idx].a;
                            dataOut2_44 <= pair_mem[nxt_idx].b;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_end) begin
                        cnt       <= '0;
                        result_44 <= res_in_44;
                        done_44   <= 1'b1;
                        busy_44   <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    busy_44 <= 1'b0;
                end
            endcase
        end
    end

endmodule
